layer_eval_sequencer: RTL and testbench

- Sequences evaluation of a layered combinational logic network through one shared layer-evaluation unit, one layer per transaction.
- Captures a primary-input vector and issues LAYERS requests to the external layer unit, feeding each result back as the next layer's operand.
- Presents the final-layer node vector on a valid/ready output port.
- Sits between a stimulus source and the layer unit. The output-combining logic is downstream.

---
 rtl/layer_seq_pkg.sv | 14 +
 rtl/layer_seq_stats.sv | 50 +++++
 rtl/layer_eval_sequencer.sv | 112 +++++++++++
 tb/tb_layer_eval_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared state encoding and default sizing for the layer evaluation sequencer.
package layer_seq_pkg;

  localparam int NUM_IN_DEF = 6;
  localparam int NODES_DEF  = 5;
  localparam int LAYERS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/layer_seq_stats.sv
// Evaluation counter and accept-to-output latency tracker for layer_eval_sequencer.
module layer_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        run_i,
  input  logic        finish_i,
  input  logic        hs_i,
  output logic [15:0] stat_evals_o,
  output logic [7:0]  stat_last_lat_o
);

  logic [15:0] evals_q, evals_d;
  logic [7:0]  lat_q, lat_d;
  logic [7:0]  last_q, last_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? 8'hFF : x + 8'd1;
  endfunction

  // lat_q holds the index of the current cycle, counted from the accept edge
  always_comb begin
    evals_d = evals_q;
    lat_d   = lat_q;
    last_d  = last_q;
    if (hs_i) evals_d = evals_q + 16'd1;
    if (start_i) begin
      lat_d = 8'd1;
    end else if (run_i) begin
      lat_d = sat_inc(lat_q);
    end
    if (finish_i) last_d = sat_inc(lat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evals_q <= '0;
      lat_q   <= '0;
      last_q  <= '0;
    end else begin
      evals_q <= evals_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
    end
  end

  assign stat_evals_o    = evals_q;
  assign stat_last_lat_o = last_q;

endmodule

// File: rtl/layer_eval_sequencer.sv
// Drives one shared layer unit through LAYERS passes per input vector.
// Optional statistics ports are built when LAYER_SEQ_STATS_EN is defined.
module layer_eval_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int NODES  = NODES_DEF,
  parameter int LAYERS = LAYERS_DEF,
  parameter int LIDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_vec,
  output logic              lay_req,
  input  logic              lay_ack,
  output logic [LIDX_W-1:0] lay_idx,
  output logic [NUM_IN-1:0] lay_pi,
  output logic [NODES-1:0]  lay_prev,
  input  logic [NODES-1:0]  lay_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NODES-1:0]  out_vec
`ifdef LAYER_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_evals,
  output logic [7:0]        stat_last_lat
`endif
);

  localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(LAYERS - 1);

  state_e              state_q, state_d;
  logic [LIDX_W-1:0]   layer_q, layer_d;
  logic [NUM_IN-1:0]   pi_q, pi_d;
  logic [NODES-1:0]    node_q, node_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      pi_q    <= '0;
      node_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      pi_q    <= pi_d;
      node_q  <= node_d;
    end
  end

  // Each ack folds the layer result back in as the next layer's operand
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    pi_d    = pi_q;
    node_d  = node_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pi_d    = in_vec;
          node_d  = '0;
          layer_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lay_ack) begin
          node_d = lay_res;
          if (layer_q == LAST_LAYER) begin
            state_d = ST_DONE;
          end else begin
            layer_d = layer_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign lay_req   = (state_q == ST_RUN);
  assign lay_idx   = layer_q;
  assign lay_pi    = pi_q;
  assign lay_prev  = node_q;
  assign out_valid = (state_q == ST_DONE);
  assign out_vec   = node_q;

`ifdef LAYER_SEQ_STATS_EN
  logic st_start, st_finish, st_hs;

  assign st_start  = (state_q == ST_IDLE) && in_valid;
  assign st_finish = (state_q == ST_RUN) && lay_ack && (layer_q == LAST_LAYER);
  assign st_hs     = (state_q == ST_DONE) && out_ready;

  layer_seq_stats u_stats (
    .clk             (clk),
    .rst             (rst),
    .start_i         (st_start),
    .run_i           (lay_req),
    .finish_i        (st_finish),
    .hs_i            (st_hs),
    .stat_evals_o    (stat_evals),
    .stat_last_lat_o (stat_last_lat)
  );
`endif

endmodule

// File: tb/tb_layer_eval_sequencer.sv
// Directed and randomized bench for layer_eval_sequencer (default and LAYERS=1 instances).
module tb_layer_eval_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready;
  logic [5:0] in_vec;
  logic       lay_req, lay_ack;
  logic [1:0] lay_idx;
  logic [5:0] lay_pi;
  logic [4:0] lay_prev, lay_res;
  logic       out_valid, out_ready;
  logic [4:0] out_vec;

  logic       in_valid1, in_ready1;
  logic [5:0] in_vec1;
  logic       lay_req1, lay_ack1;
  logic [0:0] lay_idx1;
  logic [5:0] lay_pi1;
  logic [4:0] lay_prev1, lay_res1;
  logic       out_valid1, out_ready1;
  logic [4:0] out_vec1;

`ifdef LAYER_SEQ_STATS_EN
  logic [15:0] stat_evals, stat_evals1;
  logic [7:0]  stat_last_lat, stat_last_lat1;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int stub_mode = 0;
  int ack_wait = 0;
  int wcnt = 0;
  logic stray_ack = 1'b0;
  int exp_evals = 0;

  // Layer unit stand-in: mode 0 is prev+idx+1, mode 1 also mixes in the primary inputs
  function automatic logic [4:0] stub_res(input int prev, input int idx, input int pi, input int mode);
    int r;
    if (mode == 0) r = prev + idx + 1;
    else r = 3 * prev + pi + 5 * idx + 1;
    return 5'(r % 32);
  endfunction

  // Node vector after evaluating the first n layers of the network
  function automatic int ref_net(input int pi, input int n, input int mode);
    int node;
    node = 0;
    for (int l = 0; l < n; l++) node = int'(stub_res(node, l, pi, mode));
    return node;
  endfunction

  assign lay_res  = stub_res(int'(lay_prev), int'(lay_idx), int'(lay_pi), stub_mode);
  assign lay_ack  = stray_ack | (lay_req && (wcnt >= ack_wait));
  assign lay_res1 = stub_res(int'(lay_prev1), int'(lay_idx1), int'(lay_pi1), 0);
  assign lay_ack1 = lay_req1;

  always @(posedge clk) wcnt <= (!lay_req || lay_ack) ? 0 : wcnt + 1;

  layer_eval_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .lay_req(lay_req), .lay_ack(lay_ack), .lay_idx(lay_idx),
    .lay_pi(lay_pi), .lay_prev(lay_prev), .lay_res(lay_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
`ifdef LAYER_SEQ_STATS_EN
    , .stat_evals(stat_evals), .stat_last_lat(stat_last_lat)
`endif
  );

  layer_eval_sequencer #(.LAYERS(1), .LIDX_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
    .lay_req(lay_req1), .lay_ack(lay_ack1), .lay_idx(lay_idx1),
    .lay_pi(lay_pi1), .lay_prev(lay_prev1), .lay_res(lay_res1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_vec(out_vec1)
`ifdef LAYER_SEQ_STATS_EN
    , .stat_evals(stat_evals1), .stat_last_lat(stat_last_lat1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [5:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    chk("in_ready_idle", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_zero_wait(input int pi, input int mode);
    for (int k = 0; k < 4; k++) begin
      chk("run_req", 32'(lay_req), 1);
      chk("run_idx", 32'(lay_idx), k);
      chk("run_pi", 32'(lay_pi), pi);
      chk("run_prev", 32'(lay_prev), ref_net(pi, k, mode));
      chk("run_no_out", 32'(out_valid), 0);
      step();
    end
    chk("run_out_valid", 32'(out_valid), 1);
    chk("run_out_vec", 32'(out_vec), ref_net(pi, 4, mode));
    chk("run_in_ready_done", 32'(in_ready), 0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_evals++;
    chk("hs_out_valid_low", 32'(out_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);
`ifdef LAYER_SEQ_STATS_EN
    chk("stat_evals", 32'(stat_evals), exp_evals);
`endif
  endtask

  initial begin
    int pi, aw, cyc, nb;
    logic [4:0] held;
    rst = 1'b1;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_vec1 = '0; out_ready1 = 1'b0;
    repeat (2) step();
    chk("rst_in_ready_forced", 32'(in_ready), 0);
    chk("rst_lay_req", 32'(lay_req), 0);
    chk("rst_lay_idx", 32'(lay_idx), 0);
    chk("rst_lay_pi", 32'(lay_pi), 0);
    chk("rst_lay_prev", 32'(lay_prev), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_vec", 32'(out_vec), 0);
    chk("rst1_out_valid", 32'(out_valid1), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Basic run with zero-wait acks
    accept(6'h2A);
    run_zero_wait(32'h2A, 0);
    chk("basic_out_vec_10", 32'(out_vec), 10);
`ifdef LAYER_SEQ_STATS_EN
    chk("basic_last_lat", 32'(stat_last_lat), 5);
`endif
    handshake();

    // Layer unit answers on the third cycle of every request
    ack_wait = 2;
    accept(6'h2A);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        chk("wait_req", 32'(lay_req), 1);
        chk("wait_idx", 32'(lay_idx), k);
        chk("wait_pi", 32'(lay_pi), 32'h2A);
        chk("wait_prev", 32'(lay_prev), ref_net(32'h2A, k, 0));
        chk("wait_no_out", 32'(out_valid), 0);
        step();
      end
    end
    ack_wait = 0;
    chk("wait_out_valid", 32'(out_valid), 1);
    chk("wait_out_vec", 32'(out_vec), 10);
`ifdef LAYER_SEQ_STATS_EN
    chk("wait_last_lat", 32'(stat_last_lat), 13);
`endif

    // Back-pressure in DONE while the next vector is already offered
    in_valid = 1'b1;
    in_vec   = 6'h15;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_vec", 32'(out_vec), 10);
      chk("bp_in_ready", 32'(in_ready), 0);
`ifdef LAYER_SEQ_STATS_EN
      chk("bp_evals_hold", 32'(stat_evals), exp_evals);
`endif
      step();
    end
    handshake();
    step();
    in_valid = 1'b0;
    chk("bp_accept_pi", 32'(lay_pi), 32'h15);
    run_zero_wait(32'h15, 0);
    handshake();

    // Reset while the second layer is outstanding
    accept(6'h2A);
    step();
    rst = 1'b1;
    step();
    exp_evals = 0;
    chk("midrst_lay_req", 32'(lay_req), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
`ifdef LAYER_SEQ_STATS_EN
    chk("midrst_evals", 32'(stat_evals), 0);
`endif
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_release", 32'(in_ready), 1);
    step();
    chk("midrst_no_out", 32'(out_valid), 0);
    accept(6'h07);
    run_zero_wait(32'h07, 0);
    handshake();

    // Stray ack in IDLE, then out_ready held high through RUN
    stray_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("stray_req", 32'(lay_req), 0);
      chk("stray_out_valid", 32'(out_valid), 0);
      chk("stray_in_ready", 32'(in_ready), 1);
      chk("stray_prev_hold", 32'(lay_prev), 10);
      step();
    end
    stray_ack = 1'b0;
    out_ready = 1'b1;
    accept(6'h2A);
    for (int k = 0; k < 4; k++) begin
      chk("oready_run_req", 32'(lay_req), 1);
      chk("oready_run_idx", 32'(lay_idx), k);
      chk("oready_run_no_out", 32'(out_valid), 0);
      step();
    end
    chk("oready_out_valid", 32'(out_valid), 1);
    chk("oready_out_vec", 32'(out_vec), 10);
    handshake();

    // Randomized vectors, wait states and back-pressure
    stub_mode = 1;
    for (int t = 0; t < 10; t++) begin
      pi = int'($urandom_range(0, 63));
      aw = int'($urandom_range(0, 3));
      ack_wait = aw;
      accept(6'(pi));
      chk("rnd_pi", 32'(lay_pi), pi);
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 200) begin
        step();
        cyc++;
      end
      chk("rnd_latency", 32'(cyc), 4 * (aw + 1) + 1);
      chk("rnd_out_vec", 32'(out_vec), ref_net(pi, 4, 1));
`ifdef LAYER_SEQ_STATS_EN
      chk("rnd_last_lat", 32'(stat_last_lat), 4 * (aw + 1) + 1);
`endif
      held = out_vec;
      nb = int'($urandom_range(0, 2));
      for (int i = 0; i < nb; i++) begin
        step();
        chk("rnd_bp_valid", 32'(out_valid), 1);
        chk("rnd_bp_stable", 32'(out_vec), int'(held));
      end
      handshake();
    end
    stub_mode = 0;
    ack_wait = 0;

    // Single-layer instance goes straight to DONE on the first ack
    in_valid1 = 1'b1;
    in_vec1   = 6'h01;
    chk("l1_in_ready", 32'(in_ready1), 1);
    step();
    in_valid1 = 1'b0;
    chk("l1_req", 32'(lay_req1), 1);
    chk("l1_idx", 32'(lay_idx1), 0);
    chk("l1_pi", 32'(lay_pi1), 1);
    chk("l1_no_out", 32'(out_valid1), 0);
    step();
    chk("l1_req_done", 32'(lay_req1), 0);
    chk("l1_out_valid", 32'(out_valid1), 1);
    chk("l1_out_vec", 32'(out_vec1), 1);
`ifdef LAYER_SEQ_STATS_EN
    chk("l1_last_lat", 32'(stat_last_lat1), 2);
`endif
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("l1_out_valid_low", 32'(out_valid1), 0);
    chk("l1_in_ready_back", 32'(in_ready1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
